inst_fetch_decode: RTL

Instruction fetch and decode controller for the register-file/ALU CPU datapath. It sits directly upstream of the datapath top. It steps a program counter through an external synchronous instruction ROM and decodes MIPS R-type words. It drives the register-file read/write addresses, the write enable and the 3-bit ALU operation. It runs free or single-steps from a board button.

---
 rtl/inst_fetch_decode.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_decode.sv
// Fetch/decode controller: steps pc through a synchronous ROM and decodes
// MIPS R-type words into register-file addresses, write enable and ALU_OP.
module inst_fetch_decode #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          step,
    output logic [AW-1:0] inst_addr,
    input  logic [31:0]   inst_data,
    output logic [4:0]    R_Addr_A,
    output logic [4:0]    R_Addr_B,
    output logic [4:0]    W_Addr,
    output logic          Write_Reg,
    output logic [2:0]    ALU_OP,
    output logic [AW-1:0] pc,
    output logic          illegal,
    output logic          halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    ra_q, ra_d;
    logic [4:0]    rb_q, rb_d;
    logic [4:0]    wa_q, wa_d;
    logic [2:0]    op_q, op_d;
    logic          we_ok_q, we_ok_d;
    logic          wr_q, wr_d;
    logic          ill_q, ill_d;
    logic          halt_q, halt_d;
    logic          step_q, step_d;

    logic          step_edge;
    logic          dec_ok;
    logic [2:0]    dec_op;

    always_comb begin
        dec_ok = 1'b0;
        dec_op = 3'b000;
        if (inst_data[31:26] == 6'd0) begin
            dec_ok = 1'b1;
            case (inst_data[5:0])
                6'h24:   dec_op = 3'b000;
                6'h25:   dec_op = 3'b001;
                6'h26:   dec_op = 3'b010;
                6'h27:   dec_op = 3'b011;
                6'h20:   dec_op = 3'b100;
                6'h22:   dec_op = 3'b101;
                6'h2A:   dec_op = 3'b110;
                6'h00:   dec_op = 3'b111;
                default: dec_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        wa_d      = wa_q;
        op_d      = op_q;
        we_ok_d   = we_ok_q;
        wr_d      = 1'b0;
        ill_d     = ill_q;
        halt_d    = halt_q;
        step_d    = step;
        step_edge = step & ~step_q;
        case (state_q)
            IDLE: begin
                if (run || step_edge) state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (inst_data == 32'hFFFF_FFFF) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = EXEC;
                    ra_d    = inst_data[25:21];
                    rb_d    = inst_data[20:16];
                    wa_d    = inst_data[15:11];
                    op_d    = dec_ok ? dec_op : 3'b000;
                    ill_d   = ~dec_ok;
                    we_ok_d = dec_ok && (inst_data[15:11] != 5'd0);
                end
            end
            EXEC: begin
                state_d = WB;
                wr_d    = we_ok_q;
            end
            WB: begin
                pc_d    = pc_q + AW'(1);
                addr_d  = pc_q + AW'(1);
                state_d = run ? FETCH : IDLE;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            wa_q    <= '0;
            op_q    <= '0;
            we_ok_q <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            halt_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
            op_q    <= op_d;
            we_ok_q <= we_ok_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            halt_q  <= halt_d;
            step_q  <= step_d;
        end
    end

    assign inst_addr = addr_q;
    assign pc        = pc_q;
    assign R_Addr_A  = ra_q;
    assign R_Addr_B  = rb_q;
    assign W_Addr    = wa_q;
    assign ALU_OP    = op_q;
    assign Write_Reg = wr_q;
    assign illegal   = ill_q;
    assign halted    = halt_q;

endmodule
